// File: rtl/stroke_builder.sv
// rtl/stroke_builder.sv - touch samples to line segments with pen-up timeout
module stroke_builder #(
  parameter int SCREEN_W      = 240,
  parameter int SCREEN_H      = 320,
  parameter int PEN_UP_CYCLES = 5_000_000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        touch_valid_in,
  input  logic [11:0] x_in,
  input  logic [11:0] y_in,
  input  logic [2:0]  color_in,
  input  logic        seg_ready_in,
  output logic        valid_out,
  output logic [7:0]  col1_out,
  output logic [7:0]  col2_out,
  output logic [8:0]  row1_out,
  output logic [8:0]  row2_out,
  output logic [2:0]  color_out,
  output logic        pen_down_out,
  output logic [7:0]  drop_count_out
);

  localparam int TW = $clog2(PEN_UP_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(PEN_UP_CYCLES - 1);

  typedef enum logic {IDLE = 1'b0, DOWN = 1'b1} state_t;

  state_t        state, state_next;
  logic          s1_valid;
  logic [7:0]    s1_col;
  logic [8:0]    s1_row;
  logic [2:0]    s1_color;
  logic [7:0]    last_col;
  logic [8:0]    last_row;
  logic [TW-1:0] timer;

  logic          build;
  logic          accept;
  logic          can_load;
  logic          load;
  logic          drop;
  logic          update_last;
  logic          timeout;
  logic [7:0]    seg_col1;
  logic [8:0]    seg_row1;

  // Stage 1: scale raw touch coordinates to screen pixels using the full product
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      s1_valid <= 1'b0;
      s1_col   <= '0;
      s1_row   <= '0;
      s1_color <= '0;
    end else begin
      s1_valid <= touch_valid_in;
      if (touch_valid_in) begin
        s1_col   <= 8'((24'(x_in) * 24'(SCREEN_W)) >> 12);
        s1_row   <= 9'((24'(y_in) * 24'(SCREEN_H)) >> 12);
        s1_color <= color_in;
      end
    end
  end

  // Pen-up timer: restarts on every raw strobe, saturates one short of the limit
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      timer <= '0;
    end else if (touch_valid_in) begin
      timer <= '0;
    end else if (timer != TIMER_MAX) begin
      timer <= timer + 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and segment construction; a touch in the timeout cycle keeps the stroke alive
  always_comb begin
    state_next  = state;
    build       = 1'b0;
    seg_col1    = s1_col;
    seg_row1    = s1_row;
    accept      = valid_out && seg_ready_in;
    can_load    = !valid_out || accept;
    timeout     = (state == DOWN) && !touch_valid_in && (timer == TIMER_MAX);
    case (state)
      IDLE: begin
        if (s1_valid) begin
          build      = 1'b1;
          state_next = DOWN;
        end
      end
      DOWN: begin
        if (s1_valid && ((s1_col != last_col) || (s1_row != last_row))) begin
          build    = 1'b1;
          seg_col1 = last_col;
          seg_row1 = last_row;
        end
        if (timeout) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    load        = build && can_load;
    drop        = build && !can_load;
    // A new stroke always anchors at its first point; mid-stroke only issued points advance it
    update_last = (s1_valid && (state == IDLE)) || load;
  end

  // Last issued point of the current stroke
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      last_col <= '0;
      last_row <= '0;
    end else if (update_last) begin
      last_col <= s1_col;
      last_row <= s1_row;
    end
  end

  // One-entry output register; contents held stable until accepted
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      valid_out <= 1'b0;
      col1_out  <= '0;
      col2_out  <= '0;
      row1_out  <= '0;
      row2_out  <= '0;
      color_out <= '0;
    end else if (load) begin
      valid_out <= 1'b1;
      col1_out  <= seg_col1;
      row1_out  <= seg_row1;
      col2_out  <= s1_col;
      row2_out  <= s1_row;
      color_out <= s1_color;
    end else if (accept) begin
      valid_out <= 1'b0;
    end
  end

  // Saturating count of segments lost to a full output register
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      drop_count_out <= '0;
    end else if (drop && (drop_count_out != 8'hFF)) begin
      drop_count_out <= drop_count_out + 8'd1;
    end
  end

  assign pen_down_out = (state == DOWN);

endmodule

// File: tb/tb_stroke_builder.sv
// tb/tb_stroke_builder.sv - self-checking bench for stroke_builder
module tb_stroke_builder;

  localparam int W = 240;
  localparam int H = 320;
  localparam int P = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tv = 1'b0;
  logic [11:0] x = '0;
  logic [11:0] y = '0;
  logic [2:0]  c = '0;
  logic        rdy = 1'b0;
  logic        valid;
  logic [7:0]  col1, col2;
  logic [8:0]  row1, row2;
  logic [2:0]  color;
  logic        pen;
  logic [7:0]  drops;

  stroke_builder #(.SCREEN_W(W), .SCREEN_H(H), .PEN_UP_CYCLES(P)) dut (
    .clk_in(clk), .rst_in(rst_n), .touch_valid_in(tv), .x_in(x), .y_in(y),
    .color_in(c), .seg_ready_in(rdy), .valid_out(valid), .col1_out(col1),
    .col2_out(col2), .row1_out(row1), .row2_out(row2), .color_out(color),
    .pen_down_out(pen), .drop_count_out(drops)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: the held segment, stroke state and a point in flight
  bit m_valid, m_pen, pv;
  int m_c1, m_r1, m_c2, m_r2, m_col, m_drop, m_lc, m_lr, m_since;
  int pc, pr, pcol;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_pen = 0; pv = 0; m_drop = 0; m_since = 0;
    m_c1 = 0; m_r1 = 0; m_c2 = 0; m_r2 = 0; m_col = 0; m_lc = 0; m_lr = 0;
  endtask

  task automatic offer(input int a, input int b, input int d, input int e, input int col, output bit ok);
    ok = !m_valid;
    if (ok) begin
      m_valid = 1; m_c1 = a; m_r1 = b; m_c2 = d; m_r2 = e; m_col = col;
    end else if (m_drop < 255) begin
      m_drop++;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 32'(valid), 32'(m_valid));
    chk({tag, ".pen"}, 32'(pen), 32'(m_pen));
    chk({tag, ".drops"}, 32'(drops), 32'(m_drop));
    if (m_valid) begin
      chk({tag, ".col1"}, 32'(col1), 32'(m_c1));
      chk({tag, ".row1"}, 32'(row1), 32'(m_r1));
      chk({tag, ".col2"}, 32'(col2), 32'(m_c2));
      chk({tag, ".row2"}, 32'(row2), 32'(m_r2));
      chk({tag, ".color"}, 32'(color), 32'(m_col));
    end
  endtask

  task automatic tick(input bit t, input int xx, input int yy, input int cc, input bit r);
    bit ok;
    tv = t; x = 12'(xx); y = 12'(yy); c = 3'(cc); rdy = r;
    @(posedge clk);
    if (m_valid && r) m_valid = 0;
    if (pv) begin
      if (!m_pen) begin
        m_pen = 1; m_lc = pc; m_lr = pr;
        offer(pc, pr, pc, pr, pcol, ok);
      end else if (pc != m_lc || pr != m_lr) begin
        offer(m_lc, m_lr, pc, pr, pcol, ok);
        if (ok) begin m_lc = pc; m_lr = pr; end
      end
    end
    if (t) m_since = 0;
    else begin
      m_since++;
      if (m_pen && m_since == P) m_pen = 0;
    end
    pv = t; pc = (xx * W) / 4096; pr = (yy * H) / 4096; pcol = cc;
    #1;
    check_all("step");
    tv = 0;
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, r);
  endtask

  task automatic chk_seg(input string tag, input int a, input int b, input int d, input int e);
    chk({tag, ".valid"}, 32'(valid), 1);
    chk({tag, ".col1"}, 32'(col1), 32'(a));
    chk({tag, ".row1"}, 32'(row1), 32'(b));
    chk({tag, ".col2"}, 32'(col2), 32'(d));
    chk({tag, ".row2"}, 32'(row2), 32'(e));
  endtask

  initial begin
    model_reset();
    #12;
    chk("rst.valid", 32'(valid), 0);
    chk("rst.pen", 32'(pen), 0);
    chk("rst.drops", 32'(drops), 0);
    chk("rst.coords", 32'({col1, col2, row1, row2, color}), 0);
    rst_n = 1;

    // Origin dot, one-cycle valid, then pen-up timing
    tick(1, 0, 0, 0, 1);
    chk("origin.early", 32'(valid), 0);
    tick(0, 0, 0, 0, 1);
    chk_seg("origin", 0, 0, 0, 0);
    chk("origin.pen", 32'(pen), 1);
    tick(0, 0, 0, 0, 1);
    chk("origin.gone", 32'(valid), 0);
    idle(P - 3, 1);
    chk("penup.before", 32'(pen), 1);
    tick(0, 0, 0, 0, 1);
    chk("penup.at", 32'(pen), 0);

    // Full-scale corner, then a repeated point builds nothing
    tick(1, 4095, 4095, 5, 1);
    tick(0, 0, 0, 0, 1);
    chk_seg("corner", 239, 319, 239, 319);
    chk("corner.color", 32'(color), 5);
    tick(1, 4095, 4095, 5, 1);
    tick(0, 0, 0, 0, 1);
    chk("repeat.none", 32'(valid), 0);
    idle(P + 2, 1);

    // Dot then line, strobes ten cycles apart
    tick(1, 2048, 2048, 2, 1);
    tick(0, 0, 0, 0, 1);
    chk_seg("mid.dot", 120, 160, 120, 160);
    idle(8, 1);
    tick(1, 1024, 1024, 3, 1);
    tick(0, 0, 0, 0, 1);
    chk_seg("mid.line", 120, 160, 60, 80);
    idle(P + 2, 1);

    // Backpressure drops keep continuity from the last issued point
    tick(1, 2048, 2048, 1, 0);
    idle(3, 0);
    tick(1, 1024, 1024, 1, 0);
    idle(3, 0);
    tick(1, 0, 0, 1, 0);
    idle(3, 0);
    chk_seg("bp.held", 120, 160, 120, 160);
    chk("bp.drops", 32'(drops), 2);
    tick(0, 0, 0, 0, 1);
    tick(1, 4095, 0, 4, 1);
    tick(0, 0, 0, 0, 1);
    chk_seg("bp.cont", 120, 160, 239, 0);
    idle(P + 2, 1);

    // Touch on the timeout edge keeps the stroke down
    tick(1, 100, 100, 6, 1);
    idle(P - 1, 1);
    tick(1, 3000, 3000, 6, 1);
    chk("tie.pen", 32'(pen), 1);
    tick(0, 0, 0, 0, 1);
    chk_seg("tie.line", (100 * W) / 4096, (100 * H) / 4096, (3000 * W) / 4096, (3000 * H) / 4096);
    idle(P + 2, 1);

    // Randomised traffic against the model
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(0, 60) == 0) idle(P + 3, 1'($urandom_range(0, 1)));
      tick(($urandom_range(0, 3) == 0),
           ($urandom_range(0, 5) == 0) ? 4095 : int'($urandom_range(0, 4095)),
           ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(0, 4095)),
           int'($urandom_range(0, 7)), ($urandom_range(0, 2) != 0));
    end

    // Drop counter saturation
    idle(2, 0);
    for (int i = 0; i < 300; i++) begin
      tick(1, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)), 1, 0);
      tick(0, 0, 0, 0, 0);
    end
    chk("sat.drops", 32'(drops), 255);

    // Asynchronous reset mid-cycle while a segment is held and drops are 3
    #2 rst_n = 0;
    #3 rst_n = 1;
    model_reset();
    tick(1, 500, 500, 2, 0);
    tick(1, 1500, 1500, 2, 0);
    tick(1, 2500, 2500, 2, 0);
    tick(1, 3500, 3500, 2, 0);
    tick(1, 4000, 100, 2, 0);
    chk("arst.pre.drops", 32'(drops), 3);
    chk("arst.pre.valid", 32'(valid), 1);
    #2 rst_n = 0;
    #1;
    chk("arst.valid", 32'(valid), 0);
    chk("arst.drops", 32'(drops), 0);
    chk("arst.pen", 32'(pen), 0);
    chk("arst.coords", 32'({col1, col2, row1, row2, color}), 0);
    #2 rst_n = 1;
    model_reset();
    tick(0, 0, 0, 0, 1);
    chk("arst.s1gone", 32'(valid), 0);
    tick(1, 4095, 4095, 7, 1);
    tick(0, 0, 0, 0, 1);
    chk_seg("arst.resume", 239, 319, 239, 319);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/stroke_builder.md
STROKE_BUILDER -- requirements
Module: stroke_builder

Interface
REQ-001: Parameter SCREEN_W, default 240, display width in columns.
REQ-002: Parameter SCREEN_H, default 320, display height in rows.
REQ-003: Parameter PEN_UP_CYCLES, default 5_000_000, idle clk_in cycles after the last touch sample before pen-up (50 ms at 100 MHz).
REQ-004: clk_in  input  1  system clock; all logic is on its rising edge.
REQ-005: rst_in  input  1  reset, asynchronous, active-low.
REQ-006: touch_valid_in  input  1  one-cycle strobe; x_in and y_in are valid this cycle.
REQ-007: x_in  input  12  raw touch X, 0..4095.
REQ-008: y_in  input  12  raw touch Y, 0..4095.
REQ-009: color_in  input  3  pen colour, sampled together with each touch strobe.
REQ-010: seg_ready_in  input  1  downstream display accepts a segment when this and valid_out are both high.
REQ-011: valid_out  output  1  a segment is presented on the outputs.
REQ-012: col1_out, col2_out  output  8 each  segment start and end column.
REQ-013: row1_out, row2_out  output  9 each  segment start and end row.
REQ-014: color_out  output  3  segment colour.
REQ-015: pen_down_out  output  1  high while a stroke is active.
REQ-016: drop_count_out  output  8  count of dropped segments, saturating.

Function
REQ-017: Stage 1 registers the scaled point one cycle after touch_valid_in, using the full product before the shift:
- col = (x_in*SCREEN_W)>>12
- row = (y_in*SCREEN_H)>>12
- 4095 maps to 239/319; 0 maps to 0/0.
REQ-018: Stage 1 registers color_in with the point.
REQ-019: The state machine has two states, IDLE and DOWN.
REQ-020: IDLE + stage-1 point P: build the dot segment (P,P), store P as the last point, go to DOWN, pen_down_out=1.
REQ-021: DOWN + stage-1 point P, where P differs from last point L: build the segment (L,P).
REQ-022: DOWN + stage-1 point P equal to L: build no segment; the pen-up timer still restarts.
REQ-023: The pen-up timer clears on every touch_valid_in.
REQ-024: In DOWN with no sample for PEN_UP_CYCLES consecutive cycles, go to IDLE and drop pen_down_out on that edge.
REQ-025: The pen-up transition does not affect any segment already held at the output.
REQ-026: The output register is one entry.
REQ-027: A built segment loads the output register if the register is empty, or if it is being accepted (valid_out && seg_ready_in) in that same cycle.
REQ-028: Latency from touch_valid_in to valid_out is 2 cycles.
REQ-029: While valid_out=1 and seg_ready_in=0, all segment outputs stay stable.
REQ-030: valid_out deasserts the cycle after acceptance unless a new segment loads in that cycle.
REQ-031: A built segment that cannot load is dropped and drop_count_out increments, saturating at 255.
REQ-032: On a drop, the last point is not updated, so the next accepted segment starts at the last point that was issued (stroke continuity).
REQ-033: A touch arriving in the same cycle as the pen-up timeout wins: the timer clears and the state stays DOWN.

Reset
REQ-034: While rst_in=0, the following are forced immediately, independent of clk_in:
- valid_out=0, pen_down_out=0, drop_count_out=0
- all coordinate and colour outputs 0
- state IDLE, timer 0, stage-1 valid 0
REQ-035: Reset asserted mid-transfer discards the pending segment and any stage-1 point.
REQ-036: Operation resumes on the first clk_in edge after rst_in returns high.

Verification
REQ-037: seg_ready_in=1; touch (0,0) -> 2 cycles later valid_out=1 for 1 cycle with col1=col2=0, row1=row2=0, pen_down_out=1.
REQ-038: Touch (4095,4095) -> dot at col 239, row 319.
REQ-039: Touches (2048,2048) then (1024,1024), 10 cycles apart -> dot (120,160), then segment (120,160)->(60,80).
REQ-040: seg_ready_in=0; touches (2048,2048), (1024,1024), (0,0) -> dot (120,160) held stable and drop_count_out=2; then raise seg_ready_in and touch (4095,0) -> segment (120,160)->(239,0).
REQ-041: Touch, then no samples -> pen_down_out falls exactly PEN_UP_CYCLES cycles after the strobe; the next touch yields a dot, not a line.
REQ-042: Pull rst_in low while valid_out=1, seg_ready_in=0 and drop_count_out=3 -> valid_out=0 and drop_count_out=0 before the next clk_in edge.
